e203_exu_wbck_arb: RTL and testbench

- Write-back arbiter that drives the integer register file write port (wen/idx/dat).
- Merges two sources:
  - single-cycle ALU results, passed through with zero latency;
  - long-pipe results (LSU/MULDIV), buffered in a small FIFO.
- Long-pipe results are older and normally win arbitration. A starvation counter guarantees the ALU a slot.
- Sits directly upstream of the register file in the EXU.

---
 rtl/e203_exu_pkg.sv | 18 +
 rtl/e203_exu_wbck_fifo.sv | 78 +++++++
 rtl/e203_exu_wbck_arb.sv | 118 +++++++++++
 tb/tb_e203_exu_wbck_arb.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/e203_exu_pkg.sv
// Shared EXU write-back types and constants.
//   XLEN       : width of a write-back value
//   RFIDX_W    : register-file index width
//   RF_X0_IDX  : index of the hard-wired zero register
//   wbck_req_t : one write-back request {wdat, rdidx}
package e203_exu_pkg;

    localparam int XLEN    = 32;
    localparam int RFIDX_W = 5;

    localparam logic [RFIDX_W-1:0] RF_X0_IDX = 5'd0;

    typedef struct packed {
        logic [XLEN-1:0]    wdat;
        logic [RFIDX_W-1:0] rdidx;
    } wbck_req_t;

endpackage

// File: rtl/e203_exu_wbck_fifo.sv
// Small synchronous FIFO holding long-pipe write-back requests.
//   clk, rst  : clock, asynchronous active-high reset (empties the FIFO)
//   push      : write push_data at the tail (ignored while full)
//   pop       : drop the head entry (ignored while empty)
//   head      : current head entry (zero when empty after reset)
//   full/empty/count : occupancy status, all from registered state
module e203_exu_wbck_fifo
    import e203_exu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  wbck_req_t                push_data,
    input  logic                     pop,
    output wbck_req_t                head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    wbck_req_t        mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Status decode and guarded handshakes so the buffer can never over/underflow.
    always_comb begin
        full      = (count_r == CNT_FULL);
        empty     = (count_r == '0);
        count     = count_r;
        head      = mem_r[rd_ptr_r];
        push_ok_s = push && !full;
        pop_ok_s  = pop && !empty;
    end

    // Entry storage; cleared on reset so the head is never X.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/e203_exu_wbck_arb.sv
// Integer register-file write-back arbiter.
// ALU results pass straight through to the write port; long-pipe (LSU/MULDIV)
// results are buffered in a small FIFO and normally win because they are older.
// A starvation counter forces an ALU grant after STARVE_MAX lost cycles.
//   alu_wbck_i_*   : ALU result handshake (valid/ready, wdat, rdidx)
//   longp_wbck_i_* : long-pipe result handshake (valid/ready, wdat, rdidx, err)
//   rf_wbck_o_*    : register-file write port (ena, wdat, rdidx)
//   longp_pend_o   : long-pipe FIFO holds at least one entry
module e203_exu_wbck_arb
    import e203_exu_pkg::*;
#(
    parameter int LFIFO_DEPTH = 2,
    parameter int STARVE_MAX  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               alu_wbck_i_valid,
    output logic               alu_wbck_i_ready,
    input  logic [XLEN-1:0]    alu_wbck_i_wdat,
    input  logic [RFIDX_W-1:0] alu_wbck_i_rdidx,
    input  logic               longp_wbck_i_valid,
    output logic               longp_wbck_i_ready,
    input  logic [XLEN-1:0]    longp_wbck_i_wdat,
    input  logic [RFIDX_W-1:0] longp_wbck_i_rdidx,
    input  logic               longp_wbck_i_err,
    output logic               rf_wbck_o_ena,
    output logic [XLEN-1:0]    rf_wbck_o_wdat,
    output logic [RFIDX_W-1:0] rf_wbck_o_rdidx,
    output logic               longp_pend_o
);

    localparam int CNT_W = $clog2(LFIFO_DEPTH) + 1;
    localparam int STV_W = $clog2(STARVE_MAX + 1);
    localparam logic [STV_W-1:0] STV_MAX_C = STV_W'(STARVE_MAX);
    localparam logic [STV_W-1:0] STV_ONE_C = STV_W'(1);

    wbck_req_t        push_req_s;
    wbck_req_t        head_s;
    logic             fifo_push_s;
    logic             fifo_pop_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [CNT_W-1:0] fifo_count_s;
    logic             force_alu_s;
    logic             fifo_grant_s;
    logic [STV_W-1:0] starve_cnt_r;
    logic [STV_W-1:0] starve_nxt_s;

    e203_exu_wbck_fifo #(
        .DEPTH     (LFIFO_DEPTH)
    ) u_lfifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push_s),
        .push_data (push_req_s),
        .pop       (fifo_pop_s),
        .head      (head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    // Long-pipe intake: errored or x0 results are accepted but never occupy a slot.
    always_comb begin
        push_req_s.wdat    = longp_wbck_i_wdat;
        push_req_s.rdidx   = longp_wbck_i_rdidx;
        longp_wbck_i_ready = !rst && !fifo_full_s;
        if (longp_wbck_i_valid && longp_wbck_i_ready && !longp_wbck_i_err
            && (longp_wbck_i_rdidx != RF_X0_IDX)) begin
            fifo_push_s = 1'b1;
        end else begin
            fifo_push_s = 1'b0;
        end
    end

    // Grant selection and write-port drive; the ALU path stays on the port whenever
    // the FIFO is not granted so the data/index lines are never X.
    always_comb begin
        force_alu_s  = (starve_cnt_r == STV_MAX_C);
        fifo_grant_s = !fifo_empty_s && !force_alu_s;
        fifo_pop_s   = fifo_grant_s;
        longp_pend_o = (fifo_count_s != '0);
        if (fifo_grant_s) begin
            alu_wbck_i_ready = 1'b0;
            rf_wbck_o_wdat   = head_s.wdat;
            rf_wbck_o_rdidx  = head_s.rdidx;
            rf_wbck_o_ena    = !rst && (head_s.rdidx != RF_X0_IDX);
        end else begin
            alu_wbck_i_ready = !rst;
            rf_wbck_o_wdat   = alu_wbck_i_wdat;
            rf_wbck_o_rdidx  = alu_wbck_i_rdidx;
            rf_wbck_o_ena    = !rst && alu_wbck_i_valid && (alu_wbck_i_rdidx != RF_X0_IDX);
        end
    end

    // Starvation next state: counts consecutive cycles a valid ALU result loses to the FIFO.
    always_comb begin
        if (!alu_wbck_i_valid) begin
            starve_nxt_s = '0;
        end else if (!fifo_grant_s) begin
            starve_nxt_s = '0;
        end else if (starve_cnt_r != STV_MAX_C) begin
            starve_nxt_s = starve_cnt_r + STV_ONE_C;
        end else begin
            starve_nxt_s = starve_cnt_r;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_r <= '0;
        end else begin
            starve_cnt_r <= starve_nxt_s;
        end
    end

endmodule

// File: tb/tb_e203_exu_wbck_arb.sv
// Self-checking bench for e203_exu_wbck_arb: a queue-based reference model
// predicts every cycle's outputs; scenario tasks add directed checks.
module tb_e203_exu_wbck_arb;
    import e203_exu_pkg::*;

    localparam int DEPTH = 2;
    localparam int SMAX  = 4;
    localparam int OBS_W = 3 + RFIDX_W + XLEN + 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               alu_v = 1'b0;
    logic [XLEN-1:0]    alu_d = '0;
    logic [RFIDX_W-1:0] alu_i = '0;
    logic               lp_v = 1'b0;
    logic [XLEN-1:0]    lp_d = '0;
    logic [RFIDX_W-1:0] lp_i = '0;
    logic               lp_e = 1'b0;
    logic               alu_rdy;
    logic               lp_rdy;
    logic               rf_ena;
    logic [XLEN-1:0]    rf_dat;
    logic [RFIDX_W-1:0] rf_idx;
    logic               pend;

    e203_exu_wbck_arb #(
        .LFIFO_DEPTH        (DEPTH),
        .STARVE_MAX         (SMAX)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .alu_wbck_i_valid   (alu_v),
        .alu_wbck_i_ready   (alu_rdy),
        .alu_wbck_i_wdat    (alu_d),
        .alu_wbck_i_rdidx   (alu_i),
        .longp_wbck_i_valid (lp_v),
        .longp_wbck_i_ready (lp_rdy),
        .longp_wbck_i_wdat  (lp_d),
        .longp_wbck_i_rdidx (lp_i),
        .longp_wbck_i_err   (lp_e),
        .rf_wbck_o_ena      (rf_ena),
        .rf_wbck_o_wdat     (rf_dat),
        .rf_wbck_o_rdidx    (rf_idx),
        .longp_pend_o       (pend)
    );

    always #5 clk = ~clk;

    wire [OBS_W-1:0] obs_v = {alu_rdy, lp_rdy, rf_ena, rf_idx, rf_dat, pend};
    logic [OBS_W-1:0] exp_v;

    int errors = 0;
    int checks = 0;

    // Reference state: pending long-pipe writes in order, and lost-cycle count.
    wbck_req_t q[$];
    int        starve = 0;
    bit        fg_m;
    bit        lp_rdy_m;

    // Predict this cycle's outputs from the queue model and current inputs.
    task automatic model_eval();
        wbck_req_t g;
        bit        gv;
        if (rst) begin
            q.delete();
            starve = 0;
        end
        fg_m     = (q.size() != 0) && (starve != SMAX);
        lp_rdy_m = !rst && (q.size() < DEPTH);
        if (fg_m) begin
            g  = q[0];
            gv = 1'b1;
        end else begin
            g.wdat  = alu_d;
            g.rdidx = alu_i;
            gv      = alu_v;
        end
        exp_v = {!rst && !fg_m, lp_rdy_m, !rst && gv && (g.rdidx != '0),
                 g.rdidx, g.wdat, q.size() != 0};
    endtask

    // Advance the model across the rising edge.
    task automatic model_commit();
        wbck_req_t e;
        if (rst) begin
            q.delete();
            starve = 0;
        end else begin
            if (!alu_v || !fg_m) starve = 0;
            else if (starve < SMAX) starve++;
            if (fg_m) void'(q.pop_front());
            if (lp_v && lp_rdy_m && !lp_e && (lp_i != '0)) begin
                e.wdat  = lp_d;
                e.rdidx = lp_i;
                q.push_back(e);
            end
        end
    endtask

    task automatic set_in(input logic r, input logic av, input logic [RFIDX_W-1:0] ai,
                          input logic [XLEN-1:0] ad, input logic lv,
                          input logic [RFIDX_W-1:0] li, input logic [XLEN-1:0] ld,
                          input logic le);
        @(negedge clk);
        rst = r; alu_v = av; alu_i = ai; alu_d = ad;
        lp_v = lv; lp_i = li; lp_d = ld; lp_e = le;
        #1;
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        model_commit();
    endtask

    task automatic test_reset();
        set_in(1'b1, 1'b1, 5'd7, 32'h1234, 1'b1, 5'd4, 32'h55, 1'b0);
        checks++; if (obs_v !== exp_v) begin errors++; $display("FAIL reset_vec obs=%h exp=%h", obs_v, exp_v); end
        checks++; if ({alu_rdy, lp_rdy, rf_ena, pend} !== 4'b0000) begin errors++; $display("FAIL reset_outs got=%b want=0000", {alu_rdy, lp_rdy, rf_ena, pend}); end
        tick();
        set_in(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        checks++; if (obs_v !== exp_v) begin errors++; $display("FAIL post_reset_vec obs=%h exp=%h", obs_v, exp_v); end
        checks++; if (pend !== 1'b0 || lp_rdy !== 1'b1) begin errors++; $display("FAIL post_reset_empty pend=%b lp_rdy=%b want 0/1", pend, lp_rdy); end
        tick();
    endtask

    task automatic test_alu_only();
        for (int i = 1; i < 32; i++) begin
            set_in(1'b0, 1'b1, i[4:0], 32'(i * 3), 1'b0, 5'd0, 32'h0, 1'b0);
            checks++; if (obs_v !== exp_v) begin errors++; $display("FAIL alu_vec i=%0d obs=%h exp=%h", i, obs_v, exp_v); end
            checks++;
            if (alu_rdy !== 1'b1 || rf_ena !== 1'b1 || rf_idx !== i[4:0] || rf_dat !== 32'(i * 3)) begin
                errors++; $display("FAIL alu_pass i=%0d rdy=%b ena=%b idx=%0d dat=%h want 1/1/%0d/%h", i, alu_rdy, rf_ena, rf_idx, rf_dat, i, 32'(i * 3));
            end
            tick();
        end
        set_in(1'b0, 1'b1, 5'd0, 32'h77, 1'b0, 5'd0, 32'h0, 1'b0);
        checks++; if (alu_rdy !== 1'b1 || rf_ena !== 1'b0) begin errors++; $display("FAIL alu_x0 rdy=%b ena=%b want 1/0", alu_rdy, rf_ena); end
        tick();
    endtask

    task automatic test_longp_burst();
        int pushed = 0;
        for (int c = 0; c < 5; c++) begin
            if (pushed < 3) set_in(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'(5 + pushed), 32'hA5 + 32'(pushed), 1'b0);
            else            set_in(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
            checks++; if (obs_v !== exp_v) begin errors++; $display("FAIL burst_vec c=%0d obs=%h exp=%h", c, obs_v, exp_v); end
            checks++;
            if (c >= 1 && c <= 3) begin
                if (rf_ena !== 1'b1 || rf_idx !== 5'(4 + c) || rf_dat !== 32'hA4 + 32'(c)) begin
                    errors++; $display("FAIL burst_order c=%0d ena=%b idx=%0d dat=%h want 1/%0d/%h", c, rf_ena, rf_idx, rf_dat, 4 + c, 32'hA4 + 32'(c));
                end
            end else if (rf_ena !== 1'b0) begin
                errors++; $display("FAIL burst_idle c=%0d ena=%b want 0", c, rf_ena);
            end
            if (lp_rdy_m && pushed < 3) pushed++;
            tick();
        end
    endtask

    task automatic test_err_x0();
        set_in(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99, 1'b1);
        checks++; if (obs_v !== exp_v) begin errors++; $display("FAIL err_vec obs=%h exp=%h", obs_v, exp_v); end
        checks++; if (lp_rdy !== 1'b1 || rf_ena !== 1'b0) begin errors++; $display("FAIL err_accept rdy=%b ena=%b want 1/0", lp_rdy, rf_ena); end
        tick();
        set_in(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h77, 1'b0);
        checks++; if (lp_rdy !== 1'b1 || rf_ena !== 1'b0 || pend !== 1'b0) begin errors++; $display("FAIL x0_accept rdy=%b ena=%b pend=%b want 1/0/0", lp_rdy, rf_ena, pend); end
        tick();
        set_in(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        checks++; if (pend !== 1'b0 || rf_ena !== 1'b0) begin errors++; $display("FAIL drop_nowrite pend=%b ena=%b want 0/0", pend, rf_ena); end
        tick();
    endtask

    task automatic test_starvation();
        int ctr = 1;
        set_in(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 32'h100, 1'b0);
        checks++; if (obs_v !== exp_v) begin errors++; $display("FAIL starve_pre obs=%h exp=%h", obs_v, exp_v); end
        tick();
        for (int c = 1; c <= 7; c++) begin
            set_in(1'b0, 1'b1, 5'd3, 32'hDEAD, 1'b1, 5'(10 + ctr), 32'h100 + 32'(ctr), 1'b0);
            checks++; if (obs_v !== exp_v) begin errors++; $display("FAIL starve_vec c=%0d obs=%h exp=%h", c, obs_v, exp_v); end
            if (c <= 4) begin
                checks++; if (alu_rdy !== 1'b0 || rf_ena !== 1'b1 || rf_idx === 5'd3) begin errors++; $display("FAIL starve_block c=%0d rdy=%b ena=%b idx=%0d want 0/1/fifo", c, alu_rdy, rf_ena, rf_idx); end
            end else if (c == 5) begin
                checks++; if (alu_rdy !== 1'b1 || rf_ena !== 1'b1 || rf_idx !== 5'd3 || rf_dat !== 32'hDEAD) begin errors++; $display("FAIL starve_force rdy=%b ena=%b idx=%0d dat=%h want 1/1/3/dead", alu_rdy, rf_ena, rf_idx, rf_dat); end
            end else if (c == 6) begin
                checks++; if (lp_rdy !== 1'b0 || alu_rdy !== 1'b0 || rf_ena !== 1'b1 || rf_idx === 5'd3) begin errors++; $display("FAIL full_resume lp_rdy=%b alu_rdy=%b ena=%b idx=%0d want 0/0/1/fifo", lp_rdy, alu_rdy, rf_ena, rf_idx); end
            end
            if (lp_rdy_m) ctr++;
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            set_in(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
            checks++; if (obs_v !== exp_v) begin errors++; $display("FAIL drain_vec k=%0d obs=%h exp=%h", k, obs_v, exp_v); end
            tick();
        end
        checks++; if (pend !== 1'b0) begin errors++; $display("FAIL drain_empty pend=%b want 0", pend); end
    endtask

    task automatic test_mid_reset();
        logic [XLEN-1:0] d;
        set_in(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd20, 32'h200, 1'b0);
        tick();
        for (int c = 1; c <= 5; c++) begin
            set_in(1'b0, 1'b1, 5'd3, 32'hBEEF, 1'b1, 5'(20 + c), 32'h200 + 32'(c), 1'b0);
            checks++; if (obs_v !== exp_v) begin errors++; $display("FAIL midrst_fill c=%0d obs=%h exp=%h", c, obs_v, exp_v); end
            tick();
        end
        #1;
        checks++; if (lp_rdy !== 1'b0 || pend !== 1'b1) begin errors++; $display("FAIL midrst_full lp_rdy=%b pend=%b want 0/1", lp_rdy, pend); end
        set_in(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        checks++; if (rf_ena !== 1'b0 || pend !== 1'b0) begin errors++; $display("FAIL midrst_hold ena=%b pend=%b want 0/0", rf_ena, pend); end
        tick();
        for (int k = 0; k < 2; k++) begin
            set_in(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
            checks++; if (rf_ena !== 1'b0 || pend !== 1'b0) begin errors++; $display("FAIL midrst_discard k=%0d ena=%b pend=%b want 0/0", k, rf_ena, pend); end
            tick();
        end
        d = $urandom;
        set_in(1'b0, 1'b1, 5'd17, d, 1'b0, 5'd0, 32'h0, 1'b0);
        checks++; if (alu_rdy !== 1'b1 || rf_ena !== 1'b1 || rf_idx !== 5'd17 || rf_dat !== d) begin errors++; $display("FAIL midrst_alu rdy=%b ena=%b idx=%0d dat=%h want 1/1/17/%h", alu_rdy, rf_ena, rf_idx, rf_dat, d); end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            set_in($urandom_range(0, 49) == 0,
                   $urandom_range(0, 3) != 0, RFIDX_W'($urandom_range(0, 31)), XLEN'($urandom),
                   $urandom_range(0, 2) != 0, RFIDX_W'($urandom_range(0, 31)), XLEN'($urandom),
                   $urandom_range(0, 7) == 0);
            checks++; if (obs_v !== exp_v) begin errors++; $display("FAIL random_vec c=%0d obs=%h exp=%h", c, obs_v, exp_v); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_alu_only();
        test_longp_burst();
        test_err_x0();
        test_starvation();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
